// File: rtl/opb_register_bank_ppc2simulink_if.sv
// OPB slave-side bus bundle for the register bank: master drives the OPB_* request
// signals, the slave returns the Sl_* response signals. Bit 0 is the MSB (IBM numbering).
interface opb_register_bank_ppc2simulink_if;
    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;

    modport master (
        output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

    modport slave (
        input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );
endinterface

// File: rtl/opb_register_bank_ppc2simulink.sv
// C_NUM_REGS software-writable 32-bit control registers on one OPB window, with per-register
// write strobes. Define OPB_REGBANK_STATUS_EN to add read-only status words fed by user_data_in.
module opb_register_bank_ppc2simulink #(
    parameter logic [31:0] C_BASEADDR   = 32'h0108F200,
    parameter logic [31:0] C_HIGHADDR   = 32'h0108F2FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          C_NUM_REGS   = 4,
    parameter logic [31:0] C_RESET_VAL  = 32'h00000000
) (
    input  logic                          OPB_Clk,
    input  logic                          OPB_Rst_n,
    opb_register_bank_ppc2simulink_if.slave opb,
    output logic [32*C_NUM_REGS-1:0]      user_data_out,
    output logic [C_NUM_REGS-1:0]         user_wr_strb
`ifdef OPB_REGBANK_STATUS_EN
    ,
    input  logic [32*C_NUM_REGS-1:0]      user_data_in
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [C_OPB_AWIDTH-1:0]   w_addr;
    logic [C_OPB_AWIDTH-1:0]   w_offset;
    logic [5:0]                w_idx;
    logic                      w_in_window;
    logic                      w_start;
    logic                      w_rnw;
    logic [3:0]                w_be;
    logic [C_OPB_DWIDTH-1:0]   w_wdata;
    logic [C_OPB_DWIDTH-1:0]   w_rd_data;
    logic [C_OPB_DWIDTH-1:0]   r_sl_dbus;
    logic [C_NUM_REGS-1:0]     w_wr_en;
    logic                      w_unused_bits;

    // [0:31] bus vectors land on [31:0] locals, so OPB bit 0 becomes bit 31 and BE[0] becomes w_be[3].
    assign w_addr      = opb.OPB_ABus;
    assign w_wdata     = opb.OPB_DBus;
    assign w_be        = opb.OPB_BE;
    assign w_rnw       = opb.OPB_RNW;
    assign w_offset    = w_addr - C_BASEADDR;
    assign w_idx       = w_offset[7:2];
    assign w_in_window = (w_addr >= C_BASEADDR) && (w_addr <= C_HIGHADDR);
    assign w_start     = (r_state == ST_IDLE) && opb.OPB_select && w_in_window;

    assign w_unused_bits = ^{opb.OPB_seqAddr, w_offset[C_OPB_AWIDTH-1:8], w_offset[1:0]};

`ifdef OPB_REGBANK_STATUS_EN
    logic [32*C_NUM_REGS-1:0] r_status;

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            r_status <= '0;
        end else begin
            r_status <= user_data_in;
        end
    end
`endif

    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (w_idx == 6'(i)) begin
                w_rd_data = user_data_out[32*i +: 32];
            end
`ifdef OPB_REGBANK_STATUS_EN
            if (w_idx == 6'(C_NUM_REGS + i)) begin
                w_rd_data = r_status[32*i +: 32];
            end
`endif
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start)         w_state_next = ST_ACK;
            ST_ACK:                       w_state_next = ST_WAIT;
            ST_WAIT: if (!opb.OPB_select) w_state_next = ST_IDLE;
            default:                      w_state_next = ST_IDLE;
        endcase
    end

    // Decode is registered: the request is acted on at the edge entering ACK, so data,
    // register update and strobe all become visible together with the ack.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            r_state   <= ST_IDLE;
            r_sl_dbus <= '0;
        end else begin
            r_state   <= w_state_next;
            r_sl_dbus <= (w_start && w_rnw) ? w_rd_data : '0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < C_NUM_REGS; gi++) begin : g_reg
            logic [31:0] r_reg;
            logic        r_strb;

            assign w_wr_en[gi] = w_start && !w_rnw && (w_idx == 6'(gi));

            always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
                if (!OPB_Rst_n) begin
                    r_reg  <= C_RESET_VAL;
                    r_strb <= 1'b0;
                end else begin
                    r_strb <= w_wr_en[gi];
                    if (w_wr_en[gi]) begin
                        for (int b = 0; b < 4; b++) begin
                            if (w_be[b]) begin
                                r_reg[8*b +: 8] <= w_wdata[8*b +: 8];
                            end
                        end
                    end
                end
            end

            assign user_data_out[32*gi +: 32] = r_reg;
            assign user_wr_strb[gi]           = r_strb;
        end
    endgenerate

    assign opb.Sl_DBus    = r_sl_dbus;
    assign opb.Sl_xferAck = (r_state == ST_ACK);
    assign opb.Sl_errAck  = 1'b0;
    assign opb.Sl_retry   = 1'b0;
    assign opb.Sl_toutSup = 1'b0;

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Randomized self-checking bench for opb_register_bank_ppc2simulink against an
// array-based model of the register window (status words when OPB_REGBANK_STATUS_EN).
module tb_opb_register_bank_ppc2simulink;

    localparam logic [31:0] BASE = 32'h0108F200;
    localparam logic [31:0] HIGH = 32'h0108F2FF;
    localparam logic [31:0] RSTV = 32'hDEADBEEF;
    localparam int          NREG = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    opb_register_bank_ppc2simulink_if bus();

    logic [32*NREG-1:0] user_data_out;
    logic [32*NREG-1:0] user_data_in;
    logic [NREG-1:0]    user_wr_strb;

    opb_register_bank_ppc2simulink #(
        .C_BASEADDR  (BASE),
        .C_HIGHADDR  (HIGH),
        .C_NUM_REGS  (NREG),
        .C_RESET_VAL (RSTV)
    ) dut (
        .OPB_Clk       (clk),
        .OPB_Rst_n     (rst_n),
        .opb           (bus),
        .user_data_out (user_data_out),
        .user_wr_strb  (user_wr_strb)
`ifdef OPB_REGBANK_STATUS_EN
        ,
        .user_data_in  (user_data_in)
`endif
    );

    logic [31:0] m_regs [NREG];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic in_window(input logic [31:0] a);
        return (a >= BASE) && (a <= HIGH);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'(off[7:2]);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int w;
        w = word_of(a);
        if (w < NREG) return m_regs[w];
`ifdef OPB_REGBANK_STATUS_EN
        if (w < 2*NREG) return user_data_in[32*(w-NREG) +: 32];
`endif
        return 32'h0;
    endfunction

    // BE[0] is the most significant byte lane.
    task automatic model_write(input logic [31:0] a, input logic [0:3] be, input logic [31:0] d);
        int w;
        logic [31:0] mask;
        w = word_of(a);
        mask = 32'h0;
        for (int b = 0; b < 4; b++) if (be[b]) mask[31-8*b -: 8] = 8'hFF;
        if (w < NREG) m_regs[w] = (m_regs[w] & ~mask) | (d & mask);
    endtask

    task automatic xfer(input logic [31:0] a, input logic rnw, input logic [0:3] be,
                        input logic [31:0] d, input int hold,
                        output int n_acks, output int first_edge, output logic [31:0] rdata,
                        output logic [3:0] strb_ack, output logic [3:0] strb_other,
                        output logic [31:0] dbus_idle);
        n_acks = 0; first_edge = 0; rdata = '0; strb_ack = '0; strb_other = '0; dbus_idle = '0;
        @(negedge clk);
        bus.OPB_select  = 1'b1;
        bus.OPB_ABus    = a;
        bus.OPB_RNW     = rnw;
        bus.OPB_BE      = be;
        bus.OPB_DBus    = d;
        bus.OPB_seqAddr = 1'($urandom_range(0, 1));
        for (int e = 1; e <= hold + 2; e++) begin
            if (e == hold + 1) begin
                @(negedge clk);
                bus.OPB_select = 1'b0;
                bus.OPB_ABus   = $urandom;
            end
            @(posedge clk);
            #1;
            if (bus.Sl_xferAck) n_acks++;
            if (bus.Sl_xferAck && first_edge == 0) begin
                first_edge = e;
                rdata      = bus.Sl_DBus;
                strb_ack   = user_wr_strb;
            end else begin
                strb_other |= user_wr_strb;
                if (!bus.Sl_xferAck) dbus_idle |= bus.Sl_DBus;
            end
        end
        $display("xfer addr=%h %s be=%b wdata=%h acks=%0d rdata=%h strb=%b",
                 a, rnw ? "RD" : "WR", be, d, n_acks, rdata, strb_ack);
    endtask

    task automatic run_check(input logic [31:0] a, input logic rnw, input logic [0:3] be,
                             input logic [31:0] d, input int hold, output logic [31:0] rdata);
        logic        hit;
        logic [31:0] exp_rd;
        logic [3:0]  exp_strb;
        int          n_acks, first_edge;
        logic [3:0]  strb_ack, strb_other;
        logic [31:0] dbus_idle;
        hit      = in_window(a);
        exp_rd   = hit ? model_read(a) : 32'h0;
        exp_strb = (hit && !rnw && word_of(a) < NREG) ? 4'(1 << word_of(a)) : 4'h0;
        xfer(a, rnw, be, d, hold, n_acks, first_edge, rdata, strb_ack, strb_other, dbus_idle);
        check_value("ack_count", 32'(n_acks), hit ? 32'd1 : 32'd0);
        if (hit) check_value("ack_latency", 32'(first_edge), 32'd1);
        if (hit && rnw) check_value("read_data", rdata, exp_rd);
        check_value("strobe_at_ack", 32'(strb_ack), 32'(exp_strb));
        check_value("strobe_elsewhere", 32'(strb_other), 32'h0);
        check_value("dbus_when_no_ack", dbus_idle, 32'h0);
        if (hit && !rnw) model_write(a, be, d);
        for (int i = 0; i < NREG; i++)
            check_value($sformatf("reg%0d", i), user_data_out[32*i +: 32], m_regs[i]);
    endtask

    function automatic logic [31:0] random_addr();
        int pick;
        pick = int'($urandom_range(0, 9));
        if (pick <= 5) return BASE + 32'(4 * $urandom_range(0, NREG-1)) + 32'($urandom_range(0, 3));
        if (pick <= 7) return BASE + 32'(4 * $urandom_range(NREG, 63));
        if (pick == 8) return BASE - 32'(4 * $urandom_range(1, 64));
        return HIGH + 32'($urandom_range(1, 256));
    endfunction

    initial begin
        logic [31:0] rd;
        bus.OPB_select  = 1'b0;
        bus.OPB_ABus    = '0;
        bus.OPB_RNW     = 1'b0;
        bus.OPB_BE      = '0;
        bus.OPB_DBus    = '0;
        bus.OPB_seqAddr = 1'b0;
        user_data_in    = {$urandom, $urandom, $urandom, 32'hCAFE0001};
        for (int i = 0; i < NREG; i++) m_regs[i] = RSTV;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NREG; i++)
            check_value($sformatf("reset_reg%0d", i), user_data_out[32*i +: 32], RSTV);
        check_value("reset_ack", 32'(bus.Sl_xferAck), 32'h0);
        check_value("reset_dbus", bus.Sl_DBus, 32'h0);
        check_value("reset_strobe", 32'(user_wr_strb), 32'h0);
        check_value("errack", 32'(bus.Sl_errAck), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_check(32'h0108F204, 1'b0, 4'b1111, 32'h12345678, 1, rd);
        check_value("reg1_full_write", user_data_out[63:32], 32'h12345678);
        run_check(32'h0108F204, 1'b1, 4'b0000, 32'h0, 1, rd);
        check_value("reg1_readback", rd, 32'h12345678);
        run_check(32'h0108F204, 1'b0, 4'b0101, 32'hAABBCCDD, 1, rd);
        check_value("reg1_byte_write", user_data_out[63:32], 32'h12BB56DD);
        run_check(32'h0108F204, 1'b1, 4'b1111, 32'h0, 5, rd);
        run_check(32'h0108F2F0, 1'b1, 4'b1111, 32'h0, 1, rd);
        check_value("unmapped_read", rd, 32'h0);
        run_check(32'h0108F300, 1'b0, 4'b1111, 32'hFFFFFFFF, 1, rd);
        run_check(32'h0108F000, 1'b0, 4'b0000, 32'h0, 1, rd);
        run_check(32'h0108F210, 1'b1, 4'b1111, 32'h0, 1, rd);
`ifdef OPB_REGBANK_STATUS_EN
        check_value("status0_read", rd, 32'hCAFE0001);
`else
        check_value("status0_absent", rd, 32'h0);
`endif
        run_check(32'h0108F210, 1'b0, 4'b1111, 32'h55AA55AA, 1, rd);

        // Randomized traffic
        for (int t = 0; t < 80; t++) begin
            run_check(random_addr(), 1'($urandom_range(0, 1)), 4'($urandom), $urandom,
                      int'($urandom_range(1, 4)), rd);
        end

        // Reset asserted during the ACK cycle of a write
        @(negedge clk);
        bus.OPB_select = 1'b1;
        bus.OPB_ABus   = BASE + 32'd8;
        bus.OPB_RNW    = 1'b0;
        bus.OPB_BE     = 4'b1111;
        bus.OPB_DBus   = 32'h0BADF00D;
        @(posedge clk);
        #1;
        check_value("midreset_ack_before", 32'(bus.Sl_xferAck), 32'h1);
        check_value("midreset_reg2_written", user_data_out[95:64], 32'h0BADF00D);
        check_value("midreset_strobe_before", 32'(user_wr_strb), 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        check_value("midreset_ack_after", 32'(bus.Sl_xferAck), 32'h0);
        check_value("midreset_strobe_after", 32'(user_wr_strb), 32'h0);
        for (int i = 0; i < NREG; i++) begin
            m_regs[i] = RSTV;
            check_value($sformatf("midreset_reg%0d", i), user_data_out[32*i +: 32], RSTV);
        end
        $display("xfer addr=%h WR aborted by reset", BASE + 32'd8);
        bus.OPB_select = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_check(BASE + 32'd8, 1'b1, 4'b1111, 32'h0, 1, rd);
        check_value("post_reset_reg2", rd, RSTV);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
